key_repeat_scheduler: RTL and testbench
=======================================

# key_repeat_scheduler

Command scheduler between the four debounced push-button levels and the 8-bit hex counter datapath that drives the two seven-segment digits. Arbitrates simultaneous presses, assigns ownership to one key at a time, generates initial and auto-repeat commands, and delivers them over a valid/ready handshake. The block holds no count value; the downstream counter register applies each accepted command.

## Interface
- REPEAT_DELAY, 5000000, cycles from initial command to first repeat
- REPEAT_PERIOD, 1000000, cycles between repeats (must be ≥4)
- ACCEL_AFTER, 8, repeats issued before acceleration (only with KEY_ACCEL_EN)

- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Key  in  4  debounced key levels; [0]=INC, [1]=DEC, [2]=CLR, [3]=MAX
- o_Cmd_Valid  out  1  command available
- o_Cmd  out  2  command code, stable while o_Cmd_Valid && !i_Cmd_Ready
- i_Cmd_Ready  in  1  counter accepts command this cycle
- o_Dropped  out  1  one-cycle pulse: repeat tick lost because a command was still pending
- o_Busy  out  1  a key currently owns the scheduler

## Operation
- Edge detect: r_Key_Prev <= i_Key each cycle; press = i_Key & ~r_Key_Prev.
- States: IDLE, DELAY, REPEAT, WAIT_RELEASE.
- IDLE: on any press, owner = lowest-index pressed key; issue its command. INC/DEC -> DELAY; CLR/MAX -> WAIT_RELEASE. Keys already held on entry to IDLE are ignored (no edge).
- DELAY: timer counts 0..REPEAT_DELAY-1; on terminal count, issue owner command, clear timer, -> REPEAT.
- REPEAT: timer counts 0..REPEAT_PERIOD-1; on terminal count, issue command, clear timer.
- Any state except IDLE: owner key low -> IDLE, timer and repeat count cleared the same cycle. Non-owner keys are ignored, including new presses.
- Issue: sets o_Cmd_Valid, loads o_Cmd. If o_Cmd_Valid is already set and not accepted this cycle, the new command is discarded, o_Dropped pulses, and the timer still restarts. There is no queue. The pending command keeps its value.
- Handshake: o_Cmd_Valid clears on the cycle after o_Cmd_Valid && i_Cmd_Ready. Accept and new issue in the same cycle: the new command is loaded and valid stays high.
- Owner release with a command pending: the pending command is still delivered.
- Codes: INC=0, DEC=1, CLR=2, MAX=3.

## Timing
- Reset values: o_Cmd_Valid=0, o_Cmd=0, o_Dropped=0, o_Busy=0, state IDLE, timer 0, repeat count 0, r_Key_Prev=4'b1111. The all-ones r_Key_Prev means keys held through reset are ignored until released.
- Reset mid-operation abandons any pending command and ownership.
- Press seen at edge t: o_Cmd_Valid high from t+1.
- First repeat valid at t+1+REPEAT_DELAY; later repeats every REPEAT_PERIOD cycles.
- o_Busy is high from t+1 until the cycle after owner release.
- Release at edge r: state IDLE at r+1. A fresh press is accepted at r+1 at the earliest.
- Timer width is $clog2(REPEAT_DELAY). No wrap: the timer clears at terminal count.

## Configuration
- KEY_ACCEL_EN defined: a saturating repeat count (width $clog2(ACCEL_AFTER+1)) counts repeats in the current hold. Once it reaches ACCEL_AFTER, the REPEAT terminal count becomes (REPEAT_PERIOD>>2)-1. The count clears on owner release.
- KEY_ACCEL_EN undefined: REPEAT period is fixed at REPEAT_PERIOD, and the repeat-count logic is absent.

## Structure
- Package key_sched_pkg holds:
  - the command code typedef/constants (CMD_INC, CMD_DEC, CMD_CLR, CMD_MAX);
  - the state encoding;
  - the key-index-to-command mapping.
- Sub-module key_repeat_timer contains the loadable terminal-count timer (inputs clear/enable/terminal value, output tick). The FSM, arbitration and handshake stay in the top.

## Test plan
Bench parameters: REPEAT_DELAY=10, REPEAT_PERIOD=4, ACCEL_AFTER=2.
- INC pressed 3 cycles with ready=1 -> exactly one INC valid pulse, one cycle after press; no repeat.
- INC held 30 cycles, ready=1 -> commands at t+1, t+11, t+15, t+19, t+23, t+27, t+31. With KEY_ACCEL_EN: t+1, t+11, t+15, t+19, then every 1 cycle (period 4>>2).
- Keys 1 and 2 pressed in the same cycle -> DEC issued; CLR press while DEC is held is ignored. After DEC release with CLR still held -> no command.
- DEC held, ready=0 for 12 cycles after the first command -> o_Cmd=1 held valid; o_Dropped pulses at t+11. Raising ready delivers exactly one DEC.
- MAX held 20 cycles -> single MAX command; state WAIT_RELEASE; o_Busy=1 until release+1.
- Reset asserted mid-REPEAT with INC still held -> all outputs 0. After reset deasserts, no command until INC is released and pressed again.

Source files
------------

// File: rtl/key_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_sched_pkg
// Description : Command codes, scheduler state encoding and key-to-command
//               mapping shared by the key repeat scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package key_sched_pkg;

    typedef enum logic [1:0] {
        CMD_INC = 2'd0,
        CMD_DEC = 2'd1,
        CMD_CLR = 2'd2,
        CMD_MAX = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DELAY        = 2'd1,
        ST_REPEAT       = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    function automatic cmd_t key_to_cmd(input logic [1:0] idx);
        cmd_t cmd;
        unique case (idx)
            2'd0:    cmd = CMD_INC;
            2'd1:    cmd = CMD_DEC;
            2'd2:    cmd = CMD_CLR;
            default: cmd = CMD_MAX;
        endcase
        return cmd;
    endfunction

    // Fixed priority: lowest index wins when several keys are pressed together.
    function automatic logic [1:0] lowest_key(input logic [3:0] keys);
        logic [1:0] idx;
        if (keys[0])      idx = 2'd0;
        else if (keys[1]) idx = 2'd1;
        else if (keys[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

    function automatic logic key_repeats(input logic [1:0] idx);
        return (key_to_cmd(idx) == CMD_INC) || (key_to_cmd(idx) == CMD_DEC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_repeat_timer.sv
`default_nettype none
// ============================================================================
// Module      : key_repeat_timer
// Description : Loadable terminal-count timer; ticks and self-clears when the
//               count equals the terminal value while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module key_repeat_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             tick
);

    logic [WIDTH-1:0] r_count;

    assign tick = enable && (r_count == terminal);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= tick ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_repeat_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : key_repeat_scheduler
// Description : Arbitrates push-button presses, generates initial and
//               auto-repeat commands and delivers them on a valid/ready port.
//               Define KEY_ACCEL_EN to enable repeat acceleration.
// Revision    : 1.0 - initial release
// ============================================================================
module key_repeat_scheduler
    import key_sched_pkg::*;
#(
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 1000000,
    parameter int ACCEL_AFTER   = 8
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Key,
    output logic       o_Cmd_Valid,
    output logic [1:0] o_Cmd,
    input  logic       i_Cmd_Ready,
    output logic       o_Dropped,
    output logic       o_Busy
);

    localparam int TW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [TW-1:0] C_DELAY_TC  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] C_PERIOD_TC = TW'(REPEAT_PERIOD - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_key_prev;
    logic [1:0] r_owner, w_owner_nxt;
    cmd_t       r_cmd, w_issue_cmd;
    logic       r_valid, r_dropped;
    logic [3:0] w_press;
    logic       w_owner_held, w_issue, w_stalled;
    logic       w_tmr_en, w_tick;
    logic [TW-1:0] w_repeat_tc, w_tmr_tc;

    assign w_press      = i_Key & ~r_key_prev;
    assign w_owner_held = i_Key[r_owner];
    assign w_stalled    = r_valid && !i_Cmd_Ready;

    // Timer runs only while the owner key is held in a timed state; any other
    // condition (including the release cycle) clears it.
    assign w_tmr_en = ((r_state == ST_DELAY) || (r_state == ST_REPEAT)) && w_owner_held;
    assign w_tmr_tc = (r_state == ST_REPEAT) ? w_repeat_tc : C_DELAY_TC;

`ifdef KEY_ACCEL_EN
    localparam int RCW = $clog2(ACCEL_AFTER + 1);
    logic [RCW-1:0] r_rep_cnt;
    logic           w_fast;

    assign w_fast      = (r_rep_cnt == RCW'(ACCEL_AFTER));
    assign w_repeat_tc = w_fast ? TW'((REPEAT_PERIOD >> 2) - 1) : C_PERIOD_TC;

    always_ff @(posedge i_Clk) begin
        if (i_Reset || !w_tmr_en) begin
            r_rep_cnt <= '0;
        end else if ((r_state == ST_REPEAT) && w_tick && !w_fast) begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    if (ACCEL_AFTER >= 0) begin : g_fixed_period
        assign w_repeat_tc = C_PERIOD_TC;
    end
`endif

    key_repeat_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (i_Clk),
        .rst      (i_Reset),
        .clear    (!w_tmr_en),
        .enable   (w_tmr_en),
        .terminal (w_tmr_tc),
        .tick     (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_issue     = 1'b0;
        w_issue_cmd = key_to_cmd(r_owner);
        unique case (r_state)
            ST_IDLE: begin
                if (|w_press) begin
                    w_owner_nxt = lowest_key(w_press);
                    w_issue     = 1'b1;
                    w_issue_cmd = key_to_cmd(w_owner_nxt);
                    w_state_nxt = key_repeats(w_owner_nxt) ? ST_DELAY : ST_WAIT_RELEASE;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!w_owner_held) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_REPEAT;
                end
            end
            default: begin
                if (!w_owner_held) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state    <= ST_IDLE;
            r_key_prev <= 4'b1111;
            r_owner    <= 2'd0;
            r_cmd      <= CMD_INC;
            r_valid    <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_key_prev <= i_Key;
            r_owner    <= w_owner_nxt;
            r_dropped  <= w_issue && w_stalled;
            // A stalled command keeps priority; a new issue never overwrites it.
            if (w_issue && !w_stalled) begin
                r_valid <= 1'b1;
                r_cmd   <= w_issue_cmd;
            end else if (r_valid && i_Cmd_Ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_Cmd_Valid = r_valid;
    assign o_Cmd       = r_cmd;
    assign o_Dropped   = r_dropped;
    assign o_Busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_key_repeat_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_repeat_scheduler
// Description : Scoreboard bench for key_repeat_scheduler (DELAY=10, PERIOD=4,
//               ACCEL_AFTER=2); expectations follow KEY_ACCEL_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_repeat_scheduler;
    import key_sched_pkg::*;

    typedef struct {
        int cyc;
        int cmd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'b0000;
    logic       ready = 1'b1;
    logic       cmd_valid, dropped, busy;
    logic [1:0] cmd;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   drop_q[$];

    key_repeat_scheduler #(
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4),
        .ACCEL_AFTER   (2)
    ) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Key       (key),
        .o_Cmd_Valid (cmd_valid),
        .o_Cmd       (cmd),
        .i_Cmd_Ready (ready),
        .o_Dropped   (dropped),
        .o_Busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_cmd(input int at, input int c);
        exp_t e;
        e.cyc = at;
        e.cmd = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted handshake and every drop pulse is matched
    // against the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got cmd %0d at cycle %0d, want none", cmd, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("cmd_code", int'(cmd), e.cmd);
                    check("cmd_cycle", cyc, e.cyc);
                end
            end
            if (dropped) begin
                if (drop_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_drop: got drop at cycle %0d, want none", cyc);
                end else begin
                    check("drop_cycle", cyc, drop_q.pop_front());
                end
            end
        end
    end

    task automatic settle(input string name);
        step(6);
        check({name, "_cmd_q_empty"}, exp_q.size(), 0);
        check({name, "_drop_q_empty"}, drop_q.size(), 0);
        check({name, "_busy_idle"}, int'(busy), 0);
    endtask

    initial begin
        int t;

        // Reset state
        step(3);
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_cmd", int'(cmd), 0);
        check("rst_dropped", int'(dropped), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step(3);

        // Short INC tap: one command, no repeat
        key = 4'b0001;
        t = cyc + 1;
        push_cmd(t, 0);
        step(3);
        key = 4'b0000;
        settle("tap");
        step(6);
        check("tap_no_repeat", exp_q.size(), 0);

        // INC held: initial, delay repeat, then period repeats
        key = 4'b0001;
        t = cyc + 1;
        push_cmd(t, 0);
        push_cmd(t + 10, 0);
        push_cmd(t + 14, 0);
        push_cmd(t + 18, 0);
`ifdef KEY_ACCEL_EN
        for (int k = 19; k <= 30; k++) push_cmd(t + k, 0);
`else
        push_cmd(t + 22, 0);
        push_cmd(t + 26, 0);
        push_cmd(t + 30, 0);
`endif
        step(31);
        key = 4'b0000;
        settle("hold");

        // DEC and CLR together: DEC wins, CLR ignored while DEC owns
        key = 4'b0110;
        t = cyc + 1;
        push_cmd(t, 1);
        step(2);
        key = 4'b0010;
        step(2);
        key = 4'b0110;
        step(2);
        key = 4'b0100;
        step(1);
        check("arb_busy_after_release", int'(busy), 0);
        step(8);
        key = 4'b0000;
        settle("arb");

        // DEC with stalled consumer: pending held, repeat dropped
        key = 4'b0010;
        ready = 1'b0;
        t = cyc + 1;
        push_cmd(t + 12, 1);
        drop_q.push_back(t + 10);
        step(6);
        check("stall_valid_mid", int'(cmd_valid), 1);
        check("stall_cmd_mid", int'(cmd), 1);
        step(6);
        check("stall_valid_late", int'(cmd_valid), 1);
        check("stall_cmd_late", int'(cmd), 1);
        step(1);
        ready = 1'b1;
        key = 4'b0000;
        step(1);
        check("stall_valid_cleared", int'(cmd_valid), 0);
        settle("stall");

        // MAX held: single command, waits for release
        key = 4'b1000;
        t = cyc + 1;
        push_cmd(t, 3);
        step(6);
        check("max_state", int'(dut.r_state), int'(ST_WAIT_RELEASE));
        step(14);
        check("max_busy_held", int'(busy), 1);
        key = 4'b0000;
        step(1);
        check("max_busy_released", int'(busy), 0);
        settle("max");

        // Reset mid-REPEAT with INC held; held key ignored afterwards
        key = 4'b0001;
        t = cyc + 1;
        push_cmd(t, 0);
        push_cmd(t + 10, 0);
        push_cmd(t + 14, 0);
        step(16);
        rst = 1'b1;
        step(1);
        check("mid_rst_valid", int'(cmd_valid), 0);
        check("mid_rst_cmd", int'(cmd), 0);
        check("mid_rst_dropped", int'(dropped), 0);
        check("mid_rst_busy", int'(busy), 0);
        step(1);
        rst = 1'b0;
        step(15);
        check("post_rst_no_cmd", exp_q.size(), 0);
        check("post_rst_idle", int'(busy), 0);
        key = 4'b0000;
        step(2);
        key = 4'b0001;
        t = cyc + 1;
        push_cmd(t, 0);
        step(3);
        key = 4'b0000;
        settle("repress");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
